// File: rtl/sdata_rx_if.sv
// Serial receive link bundle: frame select and data from the transmitter,
// reassembled word and status pulses back from the receiver.
interface sdata_rx_if #(
  parameter int DW = 8,
  parameter int CW = 4
);
  logic          cs_n;
  logic          sdi;
  logic [DW-1:0] rdata;
  logic [CW-1:0] raddr;
  logic          rvalid;
  logic          frame_err;
  logic          parity_err;

  modport master (
    output cs_n, sdi,
    input  rdata, raddr, rvalid, frame_err, parity_err
  );

  modport slave (
    input  cs_n, sdi,
    output rdata, raddr, rvalid, frame_err, parity_err
  );
endinterface

// File: rtl/sdata_rx.sv
// Chip-select framed serial receiver: MSB-first DW-bit words, valid/abort pulses.
// Optional trailing even-parity bit enabled by defining SDATA_RX_PARITY_EN.
module sdata_rx #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input logic       clk_cs,
  input logic       rst,
  sdata_rx_if.slave rif
);

`ifdef SDATA_RX_PARITY_EN
  localparam int FL_I = DW + 1;
`else
  localparam int FL_I = DW;
`endif
  // The shift register holds every frame bit except the last, which is taken straight from sdi.
  localparam int SW = FL_I - 1;

  localparam logic [CW-1:0] FL_C   = CW'(FL_I);
  localparam logic [CW-1:0] LAST_C = CW'(FL_I - 1);
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10,
    HOLD  = 2'b11
  } state_t;

  state_t        state_r, state_s;
  logic [SW-1:0] shreg_r, shreg_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [DW-1:0] rdata_r, rdata_s;
  logic          rvalid_r, rvalid_s;
  logic          frame_err_r, frame_err_s;

`ifdef SDATA_RX_PARITY_EN
  logic          parity_err_r, parity_err_s;

  function automatic logic even_parity(input logic [DW-1:0] d);
    return ^d;
  endfunction
`endif

  // Next-state, shift and pulse decode.
  always_comb begin
    state_s     = state_r;
    shreg_s     = shreg_r;
    cnt_s       = cnt_r;
    rdata_s     = rdata_r;
    rvalid_s    = 1'b0;
    frame_err_s = 1'b0;
`ifdef SDATA_RX_PARITY_EN
    parity_err_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (!rif.cs_n) begin
          shreg_s = {{(SW-1){1'b0}}, rif.sdi};
          cnt_s   = ONE_C;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (rif.cs_n) begin
          frame_err_s = 1'b1;
          cnt_s       = ZERO_C;
          state_s     = IDLE;
        end else if (cnt_r < LAST_C) begin
          shreg_s = {shreg_r[SW-2:0], rif.sdi};
          cnt_s   = cnt_r + ONE_C;
        end else begin
          cnt_s   = FL_C;
          state_s = DONE;
`ifdef SDATA_RX_PARITY_EN
          if (rif.sdi == even_parity(shreg_r)) begin
            rdata_s  = shreg_r;
            rvalid_s = 1'b1;
          end else begin
            parity_err_s = 1'b1;
          end
`else
          rdata_s  = {shreg_r, rif.sdi};
          rvalid_s = 1'b1;
`endif
        end
      end
      // A high select in DONE already counts as the inter-frame gap.
      DONE: begin
        if (rif.cs_n) begin
          cnt_s   = ZERO_C;
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      HOLD: begin
        if (rif.cs_n) begin
          cnt_s   = ZERO_C;
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        cnt_s   = ZERO_C;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_cs) begin
    if (rst) begin
      state_r     <= IDLE;
      shreg_r     <= {SW{1'b0}};
      cnt_r       <= ZERO_C;
      rdata_r     <= {DW{1'b0}};
      rvalid_r    <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef SDATA_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      shreg_r     <= shreg_s;
      cnt_r       <= cnt_s;
      rdata_r     <= rdata_s;
      rvalid_r    <= rvalid_s;
      frame_err_r <= frame_err_s;
`ifdef SDATA_RX_PARITY_EN
      parity_err_r <= parity_err_s;
`endif
    end
  end

  assign rif.rdata     = rdata_r;
  assign rif.raddr     = cnt_r;
  assign rif.rvalid    = rvalid_r;
  assign rif.frame_err = frame_err_r;
`ifdef SDATA_RX_PARITY_EN
  assign rif.parity_err = parity_err_r;
`else
  assign rif.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdata_rx.sv
// Self-checking bench for sdata_rx: spec vector table, directed frame sequences
// and random traffic checked against a frame-level reference model.
module tb_sdata_rx;
  localparam int DW = 8;
  localparam int CW = 4;
`ifdef SDATA_RX_PARITY_EN
  localparam int FL = DW + 1;
`else
  localparam int FL = DW;
`endif

  logic clk_cs = 1'b0;
  logic rst    = 1'b0;
  always #5 clk_cs = ~clk_cs;

  sdata_rx_if #(.DW(DW), .CW(CW)) rif ();

  sdata_rx #(.DW(DW), .CW(CW)) dut (
    .clk_cs (clk_cs),
    .rst    (rst),
    .rif    (rif)
  );

  int n_chk = 0;
  int n_err = 0;
  int rv_cnt, fe_cnt, pe_cnt;
  logic [DW-1:0] rv_q[$];

  // Reference model state: bits collected in the current frame, frame-complete flag.
  bit            m_bits[$];
  bit            m_done;
  logic [DW-1:0] m_rdata;
  logic [CW-1:0] m_raddr;
  logic          m_rvalid, m_ferr, m_perr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic c, input logic d);
    logic [DW-1:0] w;
    m_rvalid = 1'b0;
    m_ferr   = 1'b0;
    m_perr   = 1'b0;
    if (r) begin
      m_bits.delete();
      m_done  = 1'b0;
      m_rdata = '0;
      m_raddr = '0;
    end else if (c) begin
      if (m_bits.size() > 0 && !m_done) m_ferr = 1'b1;
      m_bits.delete();
      m_done  = 1'b0;
      m_raddr = '0;
    end else if (!m_done) begin
      m_bits.push_back(d);
      m_raddr = CW'(m_bits.size());
      if (m_bits.size() == FL) begin
        m_done = 1'b1;
        w = '0;
        for (int i = 0; i < DW; i++) w = (w << 1) | DW'(m_bits[i]);
        if (FL == DW + 1 && m_bits[DW] != (^w)) begin
          m_perr = 1'b1;
        end else begin
          m_rvalid = 1'b1;
          m_rdata  = w;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic d);
    rst      = r;
    rif.cs_n = c;
    rif.sdi  = d;
    @(posedge clk_cs);
    #1;
    model_update(r, c, d);
    chk("rdata",      32'(rif.rdata),      32'(m_rdata));
    chk("raddr",      32'(rif.raddr),      32'(m_raddr));
    chk("rvalid",     32'(rif.rvalid),     32'(m_rvalid));
    chk("frame_err",  32'(rif.frame_err),  32'(m_ferr));
    chk("parity_err", 32'(rif.parity_err), 32'(m_perr));
    chk("exclusive",  32'((int'(rif.rvalid) + int'(rif.frame_err) + int'(rif.parity_err)) > 1), 32'd0);
    if (rif.rvalid === 1'b1) begin
      rv_cnt++;
      rv_q.push_back(rif.rdata);
    end
    if (rif.frame_err === 1'b1) fe_cnt++;
    if (rif.parity_err === 1'b1) pe_cnt++;
  endtask

  function automatic logic bit_of(input logic [DW-1:0] w, input int i, input logic par);
    return (i < DW) ? w[DW-1-i] : par;
  endfunction

  task automatic clear_counts();
    rv_cnt = 0;
    fe_cnt = 0;
    pe_cnt = 0;
    rv_q.delete();
  endtask

  // Full frame (good parity unless bad_par) followed by one select-high gap cycle.
  task automatic send_frame(input logic [DW-1:0] w, input logic bad_par);
    for (int i = 0; i < FL; i++) step(1'b0, 1'b0, bit_of(w, i, (^w) ^ bad_par));
    step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
  endtask

  typedef struct {
    logic          rst;
    logic          cs_n;
    logic          sdi;
    logic          rvalid;
    logic          frame_err;
    logic [DW-1:0] rdata;
    logic [CW-1:0] raddr;
  } vec_t;

  vec_t tbl[FL+2];

  initial begin
    logic [DW-1:0] ad;
    logic          r, c, d;
    rif.cs_n = 1'b1;
    rif.sdi  = 1'b0;
    m_bits.delete();
    m_done = 1'b0;
    m_rdata = '0;
    m_raddr = '0;
    clear_counts();

    // Vector table: reset, frame 8'hAD MSB first, then select high.
    ad = 8'hAD;
    tbl[0] = '{rst: 1'b1, cs_n: 1'b1, sdi: 1'b0, rvalid: 1'b0, frame_err: 1'b0,
               rdata: 8'h00, raddr: 4'd0};
    for (int i = 0; i < FL; i++) begin
      tbl[i+1] = '{rst: 1'b0, cs_n: 1'b0, sdi: bit_of(ad, i, 1'b1),
                   rvalid: (i == FL - 1), frame_err: 1'b0,
                   rdata: (i == FL - 1) ? ad : 8'h00, raddr: CW'(i + 1)};
    end
    tbl[FL+1] = '{rst: 1'b0, cs_n: 1'b1, sdi: 1'b0, rvalid: 1'b0, frame_err: 1'b0,
                  rdata: ad, raddr: 4'd0};

    for (int i = 0; i < FL + 2; i++) begin
      step(tbl[i].rst, tbl[i].cs_n, tbl[i].sdi);
      chk($sformatf("tbl%0d_rdata", i),  32'(rif.rdata),     32'(tbl[i].rdata));
      chk($sformatf("tbl%0d_raddr", i),  32'(rif.raddr),     32'(tbl[i].raddr));
      chk($sformatf("tbl%0d_rvalid", i), 32'(rif.rvalid),    32'(tbl[i].rvalid));
      chk($sformatf("tbl%0d_ferr", i),   32'(rif.frame_err), 32'(tbl[i].frame_err));
    end

    // Back-to-back frames with a single gap cycle.
    clear_counts();
    send_frame(8'hAD, 1'b0);
    send_frame(8'h52, 1'b0);
    chk("b2b_rvalid_count", 32'(rv_cnt), 32'd2);
    chk("b2b_frame_err_count", 32'(fe_cnt), 32'd0);
    if (rv_q.size() == 2) begin
      chk("b2b_word0", 32'(rv_q[0]), 32'h0000_00AD);
      chk("b2b_word1", 32'(rv_q[1]), 32'h0000_0052);
    end else begin
      chk("b2b_word_queue", 32'(rv_q.size()), 32'd2);
    end

    // Abort after 5 bits following a good frame.
    send_frame(8'hAD, 1'b0);
    clear_counts();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, bit_of(8'h52, i, 1'b0));
    step(1'b0, 1'b1, 1'b0);
    chk("abort_frame_err_count", 32'(fe_cnt), 32'd1);
    chk("abort_rvalid_count", 32'(rv_cnt), 32'd0);
    chk("abort_rdata", 32'(rif.rdata), 32'h0000_00AD);
    chk("abort_raddr", 32'(rif.raddr), 32'd0);
    step(1'b0, 1'b1, 1'b0);

    // Select held low well past the frame end.
    clear_counts();
    for (int i = 0; i < FL; i++) step(1'b0, 1'b0, bit_of(8'h3C, i, ^(8'h3C)));
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      chk("hold_raddr", 32'(rif.raddr), 32'(FL));
    end
    step(1'b0, 1'b1, 1'b0);
    chk("hold_rvalid_count", 32'(rv_cnt), 32'd1);
    chk("hold_rdata", 32'(rif.rdata), 32'h0000_003C);
    chk("hold_raddr_release", 32'(rif.raddr), 32'd0);

    // Reset in the middle of a frame, then a clean frame.
    clear_counts();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, bit_of(8'hC3, i, 1'b0));
    step(1'b1, 1'b0, 1'b1);
    chk("rst_rdata", 32'(rif.rdata), 32'd0);
    chk("rst_raddr", 32'(rif.raddr), 32'd0);
    chk("rst_pulses", 32'(rv_cnt + fe_cnt + pe_cnt), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0);
    chk("rst_then_rvalid_count", 32'(rv_cnt), 32'd1);
    chk("rst_then_rdata", 32'(rif.rdata), 32'h0000_00F0);

`ifdef SDATA_RX_PARITY_EN
    // Good parity updates rdata; bad parity pulses parity_err and leaves rdata alone.
    clear_counts();
    send_frame(8'h52, 1'b0);
    send_frame(8'hAD, 1'b1);
    chk("par_rvalid_count", 32'(rv_cnt), 32'd1);
    chk("par_err_count", 32'(pe_cnt), 32'd1);
    chk("par_rdata_kept", 32'(rif.rdata), 32'h0000_0052);
    clear_counts();
    send_frame(8'hAD, 1'b0);
    chk("par_good_rdata", 32'(rif.rdata), 32'h0000_00AD);
    chk("par_good_err_count", 32'(pe_cnt), 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 99) < 12);
      d = 1'($urandom_range(0, 1));
      step(r, c, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
